// File: rtl/timer_entry_ctrl_if.sv
// Keypad/timer-side signal bundle for timer_entry_ctrl.
// master: keypad, clear and magnetron/timer status sources (top level or bench).
// slave : timer_entry_ctrl itself.
interface timer_entry_ctrl_if;
  logic [9:0] keypad;
  logic       clearn;
  logic       mag_on;
  logic       timer_zero;
  logic [3:0] timer_d;
  logic [1:0] load_sel;
  logic       loadn;
  logic       pgt_1Hz;
  logic [3:0] entry_min;
  logic [3:0] entry_tens;
  logic [3:0] entry_ones;
  logic       entry_err;

  modport master (
    output keypad, clearn, mag_on, timer_zero,
    input  timer_d, load_sel, loadn, pgt_1Hz,
    input  entry_min, entry_tens, entry_ones, entry_err
  );

  modport slave (
    input  keypad, clearn, mag_on, timer_zero,
    output timer_d, load_sel, loadn, pgt_1Hz,
    output entry_min, entry_tens, entry_ones, entry_err
  );
endinterface

// File: rtl/timer_entry_ctrl.sv
// Microwave keypad entry and timer load sequencer.
// Decodes one-hot keypad presses into a 3-digit shift-in entry, serially loads
// the digits into the min/sec timer after each accepted key, and generates the
// timer's 1 Hz count tick while the magnetron runs.
// Optional feature macro: TIMER_ENTRY_TENS_CHECK_EN -- reject keys that would
// shift a digit greater than 5 into the seconds-tens position (pulses entry_err).
module timer_entry_ctrl #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  timer_entry_ctrl_if.slave bus
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    LD_ONES,
    LD_TENS,
    LD_MIN,
    RUN,
    PAUSE
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    kq_q, kq_d;
  logic [9:0]    kp_q, kp_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [1:0]    digit_count_q, digit_count_d;
  logic [CW-1:0] presc_q, presc_d;
  logic          err_q, err_d;

  logic          kq_one_hot;
  logic          press_evt;
  logic [3:0]    press_digit;
  logic          key_reject;
  logic          tick;

  // Press detection: a fresh single key (exactly one-hot now, nothing pressed last sample).
  always_comb begin
    kq_one_hot  = (kq_q != '0) && ((kq_q & (kq_q - 10'd1)) == '0);
    press_evt   = kq_one_hot && (kp_q == '0);
    press_digit = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (kq_q[k]) press_digit = 4'(k);
    end
  end

  // Key validity: the incoming shift moves the current ones digit into seconds tens.
`ifdef TIMER_ENTRY_TENS_CHECK_EN
  always_comb key_reject = (ones_q > 4'd5);
`else
  always_comb key_reject = 1'b0;
`endif

  // Count tick is a pure decode of the registered prescaler while running.
  always_comb tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  // Keypad sampling pipeline.
  always_comb begin
    kq_d = bus.keypad;
    kp_d = kq_q;
  end

  // Next-state, entry, prescaler and error-pulse logic.
  // Priority: clear (outside RUN) > magnetron start > key event.
  always_comb begin
    state_d       = state_q;
    min_d         = min_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    digit_count_d = digit_count_q;
    presc_d       = presc_q;
    err_d         = 1'b0;

    unique case (state_q)
      IDLE, ENTRY, PAUSE: begin
        if (bus.mag_on) begin
          state_d = RUN;
        end else if (press_evt && (state_q != PAUSE)) begin
          if (key_reject) begin
            err_d = 1'b1;
          end else begin
            min_d         = tens_q;
            tens_d        = ones_q;
            ones_d        = press_digit;
            digit_count_d = (digit_count_q == 2'd3) ? 2'd3 : digit_count_q + 2'd1;
            state_d       = LD_ONES;
          end
        end
      end
      LD_ONES: state_d = LD_TENS;
      LD_TENS: state_d = LD_MIN;
      // A start request seen during the burst is honoured once the load completes.
      LD_MIN:  state_d = bus.mag_on ? RUN : ENTRY;
      RUN: begin
        presc_d = tick ? '0 : presc_q + CW'(1);
        if (!bus.mag_on) begin
          if (bus.timer_zero) begin
            state_d       = IDLE;
            min_d         = '0;
            tens_d        = '0;
            ones_d        = '0;
            digit_count_d = '0;
          end else begin
            state_d = PAUSE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.clearn && (state_q != RUN)) begin
      state_d       = IDLE;
      min_d         = '0;
      tens_d        = '0;
      ones_d        = '0;
      digit_count_d = '0;
      presc_d       = '0;
      err_d         = 1'b0;
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      kq_q          <= '0;
      kp_q          <= '0;
      min_q         <= '0;
      tens_q        <= '0;
      ones_q        <= '0;
      digit_count_q <= '0;
      presc_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      kq_q          <= kq_d;
      kp_q          <= kp_d;
      min_q         <= min_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      digit_count_q <= digit_count_d;
      presc_q       <= presc_d;
      err_q         <= err_d;
    end
  end

  // Moore output decode of the load burst.
  always_comb begin
    bus.loadn    = 1'b1;
    bus.load_sel = 2'd0;
    bus.timer_d  = 4'd0;
    unique case (state_q)
      LD_ONES: begin
        bus.loadn    = 1'b0;
        bus.load_sel = 2'd0;
        bus.timer_d  = ones_q;
      end
      LD_TENS: begin
        bus.loadn    = 1'b0;
        bus.load_sel = 2'd1;
        bus.timer_d  = tens_q;
      end
      LD_MIN: begin
        bus.loadn    = 1'b0;
        bus.load_sel = 2'd2;
        bus.timer_d  = min_q;
      end
      default: ;
    endcase
  end

  // Remaining registered outputs.
  always_comb begin
    bus.pgt_1Hz    = tick;
    bus.entry_min  = min_q;
    bus.entry_tens = tens_q;
    bus.entry_ones = ones_q;
    bus.entry_err  = err_q;
  end

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// Self-checking bench for timer_entry_ctrl (TICK_DIV = 4).
// Load bursts are checked against a scoreboard filled as keys are driven.
module tb_timer_entry_ctrl;

  logic clk = 1'b0;
  logic reset;

  timer_entry_ctrl_if bus ();

  timer_entry_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int err_cnt = 0;

  logic [5:0] exp_q[$];
  logic [3:0] m_min = '0;
  logic [3:0] m_tens = '0;
  logic [3:0] m_ones = '0;

  // Scoreboard consumer: every load strobe cycle must match the next expected {sel, digit}.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.entry_err === 1'b1) err_cnt++;
      if (bus.loadn === 1'b0) begin
        load_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load got sel=%0d d=%0d, required no load", bus.load_sel, bus.timer_d);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          if ({bus.load_sel, bus.timer_d} !== e) begin
            errors++;
            $display("FAIL load_digit got sel=%0d d=%0d, required sel=%0d d=%0d",
                     bus.load_sel, bus.timer_d, e[5:4], e[3:0]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic press(input int unsigned d);
    logic reject;
    reject = 1'b0;
`ifdef TIMER_ENTRY_TENS_CHECK_EN
    if (m_ones > 4'd5) reject = 1'b1;
`endif
    @(negedge clk);
    bus.keypad = 10'b1 << d;
    if (!reject) begin
      m_min  = m_tens;
      m_tens = m_ones;
      m_ones = 4'(d);
      exp_q.push_back({2'd0, m_ones});
      exp_q.push_back({2'd1, m_tens});
      exp_q.push_back({2'd2, m_min});
    end
    @(negedge clk);
    bus.keypad = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic tap(input int unsigned d);
    @(negedge clk);
    bus.keypad = 10'b1 << d;
    @(negedge clk);
    bus.keypad = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clearn = 1'b0;
    @(negedge clk);
    bus.clearn = 1'b1;
    m_min = '0; m_tens = '0; m_ones = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_entry(input string name);
    checks++;
    if ({bus.entry_min, bus.entry_tens, bus.entry_ones} !== {m_min, m_tens, m_ones}) begin
      errors++;
      $display("FAIL %s entry got %0d:%0d%0d required %0d:%0d%0d", name,
               bus.entry_min, bus.entry_tens, bus.entry_ones, m_min, m_tens, m_ones);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({bus.loadn, bus.load_sel, bus.timer_d, bus.pgt_1Hz, bus.entry_err} !== {1'b1, 2'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s outputs got loadn=%b sel=%0d d=%0d pgt=%b err=%b required 1 0 0 0 0", name,
               bus.loadn, bus.load_sel, bus.timer_d, bus.pgt_1Hz, bus.entry_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.keypad = '0;
    bus.clearn = 1'b1;
    bus.mag_on = 1'b0;
    bus.timer_zero = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_entry("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_entry_130();
    int l0;
    l0 = load_cnt;
    press(1);
    check_entry("entry_1");
    press(3);
    check_entry("entry_13");
    press(0);
    check_entry("entry_130");
    checks++;
    if (load_cnt - l0 !== 9) begin
      errors++;
      $display("FAIL entry_130_loads got %0d required 9", load_cnt - l0);
    end
    checks++;
    if ({bus.entry_min, bus.entry_tens, bus.entry_ones} !== {4'd1, 4'd3, 4'd0}) begin
      errors++;
      $display("FAIL entry_130_value got %0d:%0d%0d required 1:30",
               bus.entry_min, bus.entry_tens, bus.entry_ones);
    end
  endtask

  task automatic test_shift_saturate();
    do_clear();
    check_entry("cleared");
    press(5);
    press(4);
    press(3);
    press(2);
    check_entry("entry_432");
    checks++;
    if (dut.digit_count_q !== 2'd3) begin
      errors++;
      $display("FAIL digit_count got %0d required 3", dut.digit_count_q);
    end
  endtask

  task automatic test_tens_check();
    int l0, e0;
    do_clear();
    press(7);
    l0 = load_cnt;
    e0 = err_cnt;
    press(0);
    check_entry("tens_check_entry");
`ifdef TIMER_ENTRY_TENS_CHECK_EN
    checks++;
    if (load_cnt - l0 !== 0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL tens_reject got loads=%0d errs=%0d required 0 1", load_cnt - l0, err_cnt - e0);
    end
`else
    checks++;
    if (load_cnt - l0 !== 3 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL tens_accept got loads=%0d errs=%0d required 3 0", load_cnt - l0, err_cnt - e0);
    end
`endif
  endtask

  task automatic test_run_pause();
    @(negedge clk);
    bus.timer_zero = 1'b0;
    bus.mag_on = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.pgt_1Hz !== ((c == 4) || (c == 8))) begin
        errors++;
        $display("FAIL run_tick cycle %0d got %b required %b", c, bus.pgt_1Hz, (c == 4) || (c == 8));
      end
    end
    bus.mag_on = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.pgt_1Hz !== 1'b0) begin
        errors++;
        $display("FAIL pause_tick cycle %0d got %b required 0", c, bus.pgt_1Hz);
      end
    end
    check_entry("pause_entry");
    bus.mag_on = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.pgt_1Hz !== (c == 2)) begin
        errors++;
        $display("FAIL resume_tick cycle %0d got %b required %b", c, bus.pgt_1Hz, c == 2);
      end
    end
  endtask

  task automatic test_run_zero();
    int l0;
    l0 = load_cnt;
    tap(6);
    checks++;
    if (load_cnt != l0) begin
      errors++;
      $display("FAIL run_key_loads got %0d required 0", load_cnt - l0);
    end
    check_entry("run_key_ignored");
    @(negedge clk);
    bus.clearn = 1'b0;
    @(negedge clk);
    bus.clearn = 1'b1;
    @(negedge clk);
    check_entry("run_clear_ignored");
    bus.timer_zero = 1'b1;
    bus.mag_on = 1'b0;
    @(negedge clk);
    bus.timer_zero = 1'b0;
    m_min = '0; m_tens = '0; m_ones = '0;
    check_entry("zero_to_idle");
    repeat (6) @(negedge clk);
    check_idle_outputs("idle_after_zero");
  endtask

  task automatic test_clear_press();
    int l0;
    press(9);
    check_entry("pre_clear");
    l0 = load_cnt;
    @(negedge clk);
    bus.keypad = 10'b1 << 2;
    @(negedge clk);
    bus.keypad = '0;
    bus.clearn = 1'b0;
    @(negedge clk);
    bus.clearn = 1'b1;
    m_min = '0; m_tens = '0; m_ones = '0;
    repeat (5) @(negedge clk);
    check_entry("clear_wins");
    checks++;
    if (load_cnt != l0) begin
      errors++;
      $display("FAIL clear_wins_loads got %0d required 0", load_cnt - l0);
    end
  endtask

  task automatic test_reset_mid_load();
    bit found;
    found = 1'b0;
    press(4);
    @(negedge clk);
    bus.keypad = 10'b1 << 2;
    m_min = m_tens; m_tens = m_ones; m_ones = 4'd2;
    exp_q.push_back({2'd0, m_ones});
    exp_q.push_back({2'd1, m_tens});
    exp_q.push_back({2'd2, m_min});
    @(negedge clk);
    bus.keypad = '0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.loadn === 1'b0 && bus.load_sel === 2'd1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_ld_tens got none required loadn=0 sel=1 within 10 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    m_min = '0; m_tens = '0; m_ones = '0;
    check_idle_outputs("reset_mid_load");
    check_entry("reset_mid_load");
    reset = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check_idle_outputs("after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_entry_130();
    test_shift_saturate();
    test_tens_check();
    test_run_pause();
    test_run_zero();
    test_clear_press();
    test_reset_mid_load();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
